sdp_rdma_cdt_gate: RTL
======================

Name: sdp_rdma_cdt_gate

Overview:
- Credit-based admission gate between the SDP RDMA request generator (ig) and the DMA interface mux (dmaif).
- A read request is forwarded only if the latency FIFO has room for every atom that request will return.
- Credits come back one per latency-FIFO pop, reported by the egress stage.
- Provides a registered request slice, a stall/perf counter, and credit-underflow/overflow error detection.

Parameters:
- REQ_W, 79, width of the DMA read request payload (64-bit address + 15-bit size).
- SIZE_LSB, 64, LSB of the size field within the payload; the field holds atoms-1.
- SIZE_W, 15, width of the size field.
- LAT_DEPTH, 256, latency-FIFO depth in atoms, which is also the initial credit count.
- CNT_W, 9, credit counter width; must satisfy 2^CNT_W > LAT_DEPTH.

Ports:
- nvdla_core_clk, input, 1, block clock.
- nvdla_core_rst, input, 1, synchronous active-high reset.
- op_load, input, 1, layer start pulse; clears stall_cnt.
- perf_en, input, 1, enables stall counting.
- in_req_vld, input, 1, request valid from ig.
- in_req_rdy, output, 1, request ready to ig.
- in_req_pd, input, REQ_W, request payload from ig.
- out_req_vld, output, 1, request valid to dmaif.
- out_req_rdy, input, 1, request ready from dmaif.
- out_req_pd, output, REQ_W, request payload to dmaif.
- cdt_pop, input, 1, one latency-FIFO entry released (one credit returned).
- credit_avail, output, CNT_W, current free credits.
- cdt_idle, output, 1, high when credit_avail==LAT_DEPTH and !out_req_vld.
- stall_cnt, output, 32, count of cycles ig was back-pressured.
- cdt_err, output, 1, sticky error flag.

Behaviour:
- Reset values (synchronous on nvdla_core_rst): credit_avail=LAT_DEPTH, out_req_vld=0, out_req_pd=0, stall_cnt=0, cdt_err=0. cdt_pop is ignored while reset is asserted.
- need = in_req_pd[SIZE_LSB+:SIZE_W] + 1, computed at SIZE_W+1 bits with no truncation.
- slot_free = !out_req_vld | out_req_rdy.
- in_req_rdy = slot_free & (need <= credit_avail). This is combinational and does not depend on in_req_vld.
- accept = in_req_vld & in_req_rdy. On accept, out_req_pd <= in_req_pd and out_req_vld <= 1, giving 1-cycle latency.
- When out_req_vld & out_req_rdy & !accept, out_req_vld <= 0.
- out_req_pd is held stable while out_req_vld & !out_req_rdy. Back-to-back accepts at full throughput are required when dmaif is always ready and credits suffice.
- Credits are debited at accept, not at dmaif handshake.
- credit_next = credit_avail - (accept ? need : 0) + cdt_pop. A simultaneous accept and pop apply in the same cycle.
- A credit returned in cycle N is usable for an accept in cycle N+1, not in cycle N.
- Overflow: if cdt_pop arrives with credit_avail==LAT_DEPTH and no accept, set cdt_err. Credit stays saturated at LAT_DEPTH.
- Oversize request: if in_req_vld is asserted with need > LAT_DEPTH, set cdt_err. The request is never accepted and ig stays stalled; software must reset.
- cdt_err, once set, clears only on reset.
- Stall counter:
  - op_load cycle: stall_cnt <= 0, and that cycle is not counted.
  - Otherwise, if perf_en & in_req_vld & !in_req_rdy, increment.
  - Saturates at 32'hFFFFFFFF and holds when perf_en=0.
- op_load does not affect credits or the request slice. Outstanding data from a prior layer continues to drain credits back.
- Reset mid-operation drops any held request. Credits return to LAT_DEPTH; the environment must also reset the latency FIFO.

Optional Feature:
- Macro: SDP_RDMA_CDT_PERF_EN.
- Defined: stall_cnt logic as described above.
- Undefined: stall_cnt is tied to 32'h0, perf_en and op_load are unused, and no counter flops are instantiated. All other behaviour is identical.

Test Plan:
1. Reset, then single request with size=3 (need 4) and out_req_rdy=1 -> out_req_vld rises the cycle after accept with identical pd; credit_avail 256->252; after 4 cdt_pop pulses, credit_avail=256 and cdt_idle=1.
2. Exhaustion: requests with size=127 (need 128) issued back-to-back -> first two accepted on consecutive cycles, credit_avail=0; third is held with in_req_rdy=0; one cdt_pop makes credit 1 and the request is still held; after 128 pops it is accepted on the following cycle.
3. Simultaneous event: credit_avail=4, request need=4 and cdt_pop in the same cycle -> accepted, credit_avail=1 next cycle.
4. Back-pressure: out_req_rdy=0 for 5 cycles with a request held -> out_req_pd stable; next ig request is not accepted; with perf_en=1, stall_cnt=5 (macro defined) or 0 (macro undefined).
5. Errors: cdt_pop at credit_avail=256 -> cdt_err=1 and credit stays 256. Separately, request size=256 (need 257) -> never accepted and cdt_err=1. In both cases cdt_err stays high until reset.
6. Reset mid-operation: credit_avail=100 with out_req_vld=1 and cdt_pop high during reset -> after reset, out_req_vld=0, credit_avail=256, stall_cnt=0.

Source files
------------

// File: rtl/sdp_rdma_cdt_gate.sv
// Credit admission gate between SDP RDMA ig and dmaif: forwards a read request only when the latency FIFO can hold all of its atoms.
// Optional stall/perf counter is built only when SDP_RDMA_CDT_PERF_EN is defined.
module sdp_rdma_cdt_gate #(
  parameter int REQ_W     = 79,
  parameter int SIZE_LSB  = 64,
  parameter int SIZE_W    = 15,
  parameter int LAT_DEPTH = 256,
  parameter int CNT_W     = 9
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             op_load,
  input  logic             perf_en,
  input  logic             in_req_vld,
  output logic             in_req_rdy,
  input  logic [REQ_W-1:0] in_req_pd,
  output logic             out_req_vld,
  input  logic             out_req_rdy,
  output logic [REQ_W-1:0] out_req_pd,
  input  logic             cdt_pop,
  output logic [CNT_W-1:0] credit_avail,
  output logic             cdt_idle,
  output logic [31:0]      stall_cnt,
  output logic             cdt_err
);

  localparam int NEED_W = SIZE_W + 1;
  localparam int CMP_W  = (NEED_W > CNT_W) ? NEED_W : CNT_W;
  localparam logic [CMP_W-1:0] LAT_CMP = CMP_W'(LAT_DEPTH);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_DEPTH);

  logic [NEED_W-1:0] need;
  logic [CMP_W-1:0]  need_cmp;
  logic [CMP_W-1:0]  credit_cmp;
  logic              slot_free;
  logic              fits;
  logic              accept;
  logic              oversize;
  logic              overflow;
  logic [CNT_W-1:0]  debit;
  logic [CNT_W-1:0]  credit_next;

  // need is one wider than the size field so a max-size request cannot wrap to zero
  assign need       = {1'b0, in_req_pd[SIZE_LSB +: SIZE_W]} + NEED_W'(1);
  assign need_cmp   = CMP_W'(need);
  assign credit_cmp = CMP_W'(credit_avail);

  assign slot_free  = !out_req_vld || out_req_rdy;
  assign fits       = (need_cmp <= credit_cmp);
  assign in_req_rdy = slot_free && fits;
  assign accept     = in_req_vld && in_req_rdy;
  assign oversize   = (need_cmp > LAT_CMP);
  assign overflow   = cdt_pop && (credit_avail == LAT_CNT) && !accept;

  // An accepted need never exceeds credit_avail, so narrowing it to CNT_W is lossless
  assign debit = accept ? CNT_W'(need) : '0;

  always_comb begin
    credit_next = credit_avail - debit;
    if (cdt_pop && !overflow) begin
      credit_next = credit_next + CNT_W'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credit_avail <= LAT_CNT;
    end else begin
      credit_avail <= credit_next;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      out_req_vld <= 1'b0;
      out_req_pd  <= '0;
    end else if (accept) begin
      out_req_vld <= 1'b1;
      out_req_pd  <= in_req_pd;
    end else if (out_req_rdy) begin
      out_req_vld <= 1'b0;
    end
  end

  // Sticky until reset: an oversize request can never be admitted, so software must intervene
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cdt_err <= 1'b0;
    end else if (overflow || (in_req_vld && oversize)) begin
      cdt_err <= 1'b1;
    end
  end

  assign cdt_idle = (credit_avail == LAT_CNT) && !out_req_vld;

`ifdef SDP_RDMA_CDT_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stall_q <= '0;
    end else if (op_load) begin
      stall_q <= '0;
    end else if (perf_en && in_req_vld && !in_req_rdy && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_perf;
  assign unused_perf = perf_en ^ op_load;
  assign stall_cnt   = 32'h0;
`endif

endmodule
